// File: rtl/iir_sos_ctrl_if.sv
// Bundle between the biquad-cascade controller, its coefficient ROM, the sections'
// coefficient write port and the upstream sample source.
interface iir_sos_ctrl_if #(
    parameter int N_SOS   = 4,
    parameter int COEFF_W = 16,
    parameter int ADDR_W  = 4
);
    logic               start_load;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COEFF_W-1:0] rom_data;
    logic [N_SOS-1:0]   c_we;
    logic [1:0]         c_addr;
    logic [COEFF_W-1:0] c_in;
    logic               coeff_ok;
    logic               load_done;
    logic               samp_valid;
    logic               ready;
    logic [N_SOS-1:0]   ce;
    logic               mult_sel;
    logic               dout_valid;
    logic               overrun;

    modport master (
        input  start_load, rom_data, samp_valid,
        output rom_addr, c_we, c_addr, c_in, coeff_ok, load_done,
               ready, ce, mult_sel, dout_valid, overrun
    );

    modport slave (
        output start_load, rom_data, samp_valid,
        input  rom_addr, c_we, c_addr, c_in, coeff_ok, load_done,
               ready, ce, mult_sel, dout_valid, overrun
    );
endinterface

// File: rtl/iir_sos_ctrl.sv
// Sequencer for a cascade of biquad sections: loads coefficients from a ROM into
// every section, then steps the sections one frame at a time for each input sample.
module iir_sos_ctrl #(
    parameter int N_SOS   = 4,
    parameter int COEFF_W = 16,
    parameter int ADDR_W  = 4,
    parameter int CE_LEN  = 3
) (
    input  logic           clk,
    input  logic           rst,
    iir_sos_ctrl_if.master bus
);
    localparam int F      = CE_LEN + 1;
    localparam int WCNT_W = $clog2(4 * N_SOS) + 1;
    localparam int FC_W   = $clog2(F);
    localparam int SC_W   = (N_SOS > 1) ? $clog2(N_SOS) : 1;

    localparam logic [WCNT_W-1:0] W_LAST  = WCNT_W'(4 * N_SOS - 1);
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(F - 1);
    localparam logic [FC_W-1:0]   FC_CE   = FC_W'(CE_LEN);
    localparam logic [SC_W-1:0]   SC_LAST = SC_W'(N_SOS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state;

    logic [WCNT_W-1:0] w_cnt;
    logic [WCNT_W-1:0] w_p1;
    logic              iss_vld_p0;
    logic              rd_vld_p1;
    logic              wr_last_p2;
    logic [FC_W-1:0]   fcnt;
    logic [FC_W-1:0]   fcnt_n;
    logic [SC_W-1:0]   scnt;
    logic [SC_W-1:0]   scnt_n;
    logic              run_end;

    // Next frame position; run_end marks the last cycle of the last section's frame.
    always_comb begin
        fcnt_n  = fcnt + 1'b1;
        scnt_n  = scnt;
        run_end = 1'b0;
        if (fcnt == FC_LAST) begin
            fcnt_n = '0;
            if (scnt == SC_LAST) begin
                run_end = 1'b1;
            end else begin
                scnt_n = scnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            w_cnt          <= '0;
            w_p1           <= '0;
            iss_vld_p0     <= 1'b0;
            rd_vld_p1      <= 1'b0;
            wr_last_p2     <= 1'b0;
            fcnt           <= '0;
            scnt           <= '0;
            bus.rom_addr   <= '0;
            bus.c_we       <= '0;
            bus.c_addr     <= '0;
            bus.c_in       <= '0;
            bus.coeff_ok   <= 1'b0;
            bus.load_done  <= 1'b0;
            bus.ready      <= 1'b0;
            bus.ce         <= '0;
            bus.mult_sel   <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.load_done  <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.c_we       <= '0;
            bus.overrun    <= bus.overrun | (bus.samp_valid & ~bus.ready);

            case (state)
                IDLE: begin
                    if (bus.start_load) begin
                        state        <= LOAD;
                        bus.ready    <= 1'b0;
                        w_cnt        <= '0;
                        bus.rom_addr <= '0;
                        iss_vld_p0   <= 1'b1;
                        rd_vld_p1    <= 1'b0;
                        wr_last_p2   <= 1'b0;
                    end else if (bus.samp_valid && bus.coeff_ok) begin
                        state        <= RUN;
                        bus.ready    <= 1'b0;
                        fcnt         <= '0;
                        scnt         <= '0;
                        bus.ce       <= N_SOS'(1);
                        bus.mult_sel <= 1'b0;
                    end
                end

                LOAD: begin
                    // p0 -> p1: address issued, ROM data returns next cycle
                    if (iss_vld_p0) begin
                        rd_vld_p1 <= 1'b1;
                        w_p1      <= w_cnt;
                        if (w_cnt == W_LAST) begin
                            iss_vld_p0 <= 1'b0;
                        end else begin
                            w_cnt        <= w_cnt + 1'b1;
                            bus.rom_addr <= ADDR_W'(w_cnt + 1'b1);
                        end
                    end else begin
                        rd_vld_p1 <= 1'b0;
                    end

                    // p1 -> p2: capture ROM data into the section write port
                    wr_last_p2 <= 1'b0;
                    if (rd_vld_p1) begin
                        bus.c_we   <= N_SOS'(1) << w_p1[WCNT_W-1:2];
                        bus.c_addr <= w_p1[1:0];
                        bus.c_in   <= bus.rom_data;
                        wr_last_p2 <= (w_p1 == W_LAST);
                    end

                    if (wr_last_p2) begin
                        state         <= IDLE;
                        bus.load_done <= 1'b1;
                        bus.coeff_ok  <= 1'b1;
                        bus.ready     <= 1'b1;
                    end
                end

                RUN: begin
                    fcnt <= fcnt_n;
                    scnt <= scnt_n;
                    if (run_end) begin
                        state          <= IDLE;
                        bus.ce         <= '0;
                        bus.mult_sel   <= 1'b0;
                        bus.dout_valid <= 1'b1;
                        bus.ready      <= 1'b1;
                    end else begin
                        bus.ce       <= (fcnt_n < FC_CE) ? (N_SOS'(1) << scnt_n) : '0;
                        bus.mult_sel <= (fcnt_n != '0) && (fcnt_n < FC_CE);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_sos_ctrl.sv
// Scoreboard bench for iir_sos_ctrl: stimulus queues expected writes, ce frames,
// load_done and dout_valid events; a negedge monitor pops and compares them.
module tb_iir_sos_ctrl;
    localparam int N_SOS   = 4;
    localparam int COEFF_W = 16;
    localparam int ADDR_W  = 4;
    localparam int CE_LEN  = 3;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    ev_t  q_wr[$];
    ev_t  q_ce[$];
    ev_t  q_ld[$];
    ev_t  q_dv[$];
    ev_t  mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iir_sos_ctrl_if #(.N_SOS(N_SOS), .COEFF_W(COEFF_W), .ADDR_W(ADDR_W)) bus ();

    iir_sos_ctrl #(
        .N_SOS(N_SOS), .COEFF_W(COEFF_W), .ADDR_W(ADDR_W), .CE_LEN(CE_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Synchronous ROM: word w holds 16'h1000 + w
    always @(posedge clk) bus.rom_data <= 16'h1000 + 16'(bus.rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input string name, input ev_t e, input logic [31:0] act);
        checks++;
        if (e.cyc != cyc || act !== e.val) begin
            errors++;
            $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                     name, act, cyc, e.val, e.cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event %h at cycle %0d", name, act, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.c_we != '0) begin
                if (q_wr.size() == 0) unexpected("coef_write", 32'({bus.c_we, bus.c_addr, bus.c_in}));
                else begin
                    mon_e = q_wr.pop_front();
                    check_ev("coef_write", mon_e, 32'({bus.c_we, bus.c_addr, bus.c_in}));
                end
            end
            if (bus.ce != '0 || bus.mult_sel) begin
                if (q_ce.size() == 0) unexpected("ce_frame", 32'({bus.ce, bus.mult_sel}));
                else begin
                    mon_e = q_ce.pop_front();
                    check_ev("ce_frame", mon_e, 32'({bus.ce, bus.mult_sel}));
                end
            end
            if (bus.load_done) begin
                if (q_ld.size() == 0) unexpected("load_done", 32'({bus.coeff_ok, bus.ready}));
                else begin
                    mon_e = q_ld.pop_front();
                    check_ev("load_done", mon_e, 32'({bus.coeff_ok, bus.ready}));
                end
            end
            if (bus.dout_valid) begin
                if (q_dv.size() == 0) unexpected("dout_valid", 32'({bus.ready, bus.ce}));
                else begin
                    mon_e = q_dv.pop_front();
                    check_ev("dout_valid", mon_e, 32'({bus.ready, bus.ce}));
                end
            end
        end
    end

    // n = cycle in which start_load is presented; write w lands in cycle n+w+3
    task automatic push_load(input int n);
        logic [3:0]  we;
        logic [1:0]  ad;
        logic [15:0] dat;
        for (int w = 0; w < 16; w++) begin
            we  = 4'(1 << (w / 4));
            ad  = 2'(w % 4);
            dat = 16'h1000 + 16'(w);
            q_wr.push_back('{n + w + 3, 32'({we, ad, dat})});
        end
        q_ld.push_back('{n + 19, 32'(2'b11)});
    endtask

    // Frames of 4 cycles: ce[k] high at k*4+1..k*4+3, mult_sel 0,1,1; events up to 'upto'
    task automatic push_run(input int n, input int upto);
        logic [3:0] ce_v;
        for (int k = 0; k < 4; k++) begin
            for (int f = 0; f < 3; f++) begin
                if (k * 4 + f + 1 <= upto) begin
                    ce_v = 4'(1 << k);
                    q_ce.push_back('{n + k * 4 + f + 1, 32'({ce_v, f != 0}) });
                end
            end
        end
        if (upto >= 17) q_dv.push_back('{n + 17, 32'(5'b10000)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(q_wr.size() + q_ce.size() + q_ld.size() + q_dv.size()), 32'd0);
    endtask

    int n;

    initial begin
        rst            = 1'b1;
        bus.start_load = 1'b0;
        bus.samp_valid = 1'b0;
        repeat (3) tick();
        check("reset_ctrl", 32'({bus.coeff_ok, bus.load_done, bus.ready, bus.ce,
                                 bus.mult_sel, bus.dout_valid, bus.overrun}), 32'd0);
        check("reset_bus", 32'({bus.rom_addr, bus.c_we, bus.c_addr}), 32'd0);
        check("reset_cin", 32'(bus.c_in), 32'd0);
        rst = 1'b0;
        tick();

        // Sample before any load: ignored, overrun set
        bus.samp_valid = 1'b1;
        tick();
        bus.samp_valid = 1'b0;
        repeat (20) tick();
        check("noload_overrun", 32'(bus.overrun), 32'd1);
        check("noload_ready", 32'({bus.ready, bus.coeff_ok}), 32'd0);

        rst = 1'b1;
        tick();
        check("reset_overrun_clr", 32'(bus.overrun), 32'd0);
        rst = 1'b0;
        tick();

        // Coefficient load
        bus.start_load = 1'b1;
        push_load(cyc);
        tick();
        bus.start_load = 1'b0;
        repeat (20) tick();
        check("load_coeff_ok", 32'({bus.coeff_ok, bus.ready}), 32'b11);
        check_drained("load_drained");

        // One sample through the cascade
        bus.samp_valid = 1'b1;
        push_run(cyc, 17);
        tick();
        bus.samp_valid = 1'b0;
        repeat (18) tick();
        check("run_no_overrun", 32'(bus.overrun), 32'd0);
        check_drained("run_drained");

        // Sample during RUN cycle 6 dropped; start_load in RUN ignored
        bus.samp_valid = 1'b1;
        n = cyc;
        push_run(n, 17);
        tick();
        repeat (5) tick();
        bus.samp_valid = 1'b1;
        tick();
        bus.samp_valid = 1'b0;
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
        repeat (12) tick();
        check("run_overrun", 32'(bus.overrun), 32'd1);
        check_drained("overrun_drained");

        // start_load and samp_valid together: load wins, no ce
        bus.start_load = 1'b1;
        bus.samp_valid = 1'b1;
        push_load(cyc);
        tick();
        bus.start_load = 1'b0;
        bus.samp_valid = 1'b0;
        repeat (20) tick();
        check("prio_coeff_ok", 32'(bus.coeff_ok), 32'd1);
        check_drained("prio_drained");

        // Reset in RUN cycle 10
        bus.samp_valid = 1'b1;
        n = cyc;
        push_run(n, 9);
        tick();
        repeat (9) tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_ce", 32'({bus.ce, bus.mult_sel}), 32'd0);
        check("rst_cwe", 32'(bus.c_we), 32'd0);
        check("rst_coeff_ok", 32'({bus.coeff_ok, bus.ready}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus.samp_valid = 1'b1;
        tick();
        bus.samp_valid = 1'b0;
        repeat (20) tick();
        check("postrst_ignored", 32'({bus.coeff_ok, bus.ready, bus.overrun}), 32'b001);
        check_drained("postrst_drained");

        // Reload, then a sample runs again
        bus.start_load = 1'b1;
        push_load(cyc);
        tick();
        bus.start_load = 1'b0;
        repeat (20) tick();
        bus.samp_valid = 1'b1;
        push_run(cyc, 17);
        tick();
        bus.samp_valid = 1'b0;
        repeat (18) tick();
        check("reload_ready", 32'({bus.coeff_ok, bus.ready}), 32'b11);
        check_drained("reload_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
